lcd_spi_arbiter: RTL and testbench

Round-robin arbiter that shares the single `spi_master` instance driving the PCD8544 LCD between `NREQ` byte-stream requesters (init/clean sequencer, sprite drawers, status-icon drawers). Each requester presents one byte at a time with its D/C flag and marks packet ends with `req_last`. Ownership is locked for a whole packet, so a cursor-set command followed by its pixel data is never interleaved with another requester's bytes. The block sits between the requester FSMs and `spi_master`, and owns `spi_start`.

---
 rtl/lcd_spi_arbiter.sv | 130 +++++++++++++
 tb/tb_lcd_spi_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_spi_arbiter.sv
// Round-robin arbiter sharing one spi_master between NREQ byte-stream requesters.
// Ownership is locked per packet; a stalled owner is released after TIMEOUT idle cycles.
module lcd_spi_arbiter #(
   parameter int NREQ    = 3,
   parameter int TIMEOUT = 255
) (
   input  logic              clock,
   input  logic              Reset,
   input  logic [NREQ-1:0]   req,
   input  logic [8*NREQ-1:0] req_data,
   input  logic [NREQ-1:0]   req_dc,
   input  logic [NREQ-1:0]   req_last,
   output logic [NREQ-1:0]   grant,
   output logic [NREQ-1:0]   req_ack,
   output logic [7:0]        spi_data,
   output logic              spi_command,
   output logic              spi_start,
   input  logic              spi_avail,
   input  logic              spi_busy,
   output logic              idle,
   output logic              err_abort
);
   localparam int PW = $clog2(NREQ);
   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, XFER, HOLD} state_t;

   state_t                 state, state_nx;
   logic [PW-1:0]          owner, owner_nx, rr_ptr, rr_ptr_nx;
   logic [CW-1:0]          cnt, cnt_nx;
   logic                   start_nx;
   logic [NREQ-1:0]        own_oh;
   logic [NREQ-1:0][7:0]   data_arr;
   logic                   ack, abort, busy_own;
   logic [PW:0]            pick_idle, pick_next;

   // {found, index} of the first set bit at or after 'from', wrapping.
   function automatic logic [PW:0] rr_pick(input logic [NREQ-1:0] mask,
                                           input logic [PW-1:0]   from);
      logic [PW-1:0] idx;
      logic [PW:0]   pick;
      pick = '0;
      for (int i = NREQ-1; i >= 0; i--) begin
         idx = PW'((int'(from) + i) % NREQ);
         if (mask[idx]) pick = {1'b1, idx};
      end
      return pick;
   endfunction

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(NREQ-1)) ? '0 : p + 1'b1;
   endfunction

   assign data_arr    = req_data;
   assign own_oh      = NREQ'(1) << owner;
   assign busy_own    = (state != IDLE);
   assign grant       = busy_own ? own_oh : '0;
   assign ack         = (state == XFER) && spi_avail;
   assign req_ack     = ack ? own_oh : '0;
   assign abort       = (state == HOLD) && (cnt == CW'(TIMEOUT));
   assign err_abort   = abort;
   assign spi_data    = busy_own ? data_arr[owner] : 8'h00;
   assign spi_command = busy_own && req_dc[owner];
   assign idle        = (state == IDLE) && !spi_busy;
   assign pick_idle   = rr_pick(req, rr_ptr);
   // Handover only considers the others, searching from the slot after the owner.
   assign pick_next   = rr_pick(req & ~own_oh, ptr_inc(owner));

   always_comb begin
      state_nx  = state;
      owner_nx  = owner;
      rr_ptr_nx = rr_ptr;
      cnt_nx    = cnt;
      start_nx  = 1'b0;
      case (state)
         IDLE: begin
            if (pick_idle[PW]) begin
               state_nx = XFER;
               owner_nx = pick_idle[PW-1:0];
               start_nx = 1'b1;
            end
         end
         XFER: begin
            start_nx = 1'b1;
            // An ack outranks a same-cycle req drop: the byte was taken.
            if (ack && req_last[owner]) begin
               rr_ptr_nx = ptr_inc(owner);
               if (pick_next[PW]) begin
                  owner_nx = pick_next[PW-1:0];
               end else begin
                  state_nx = IDLE;
                  start_nx = 1'b0;
               end
            end else if (!ack && !req[owner]) begin
               state_nx = HOLD;
               start_nx = 1'b0;
               cnt_nx   = '0;
            end
         end
         HOLD: begin
            if (abort) begin
               state_nx  = IDLE;
               rr_ptr_nx = ptr_inc(owner);
            end else if (req[owner]) begin
               state_nx = XFER;
               start_nx = 1'b1;
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge Reset) begin
      if (Reset) begin
         state     <= IDLE;
         owner     <= '0;
         rr_ptr    <= '0;
         cnt       <= '0;
         spi_start <= 1'b0;
      end else begin
         state     <= state_nx;
         owner     <= owner_nx;
         rr_ptr    <= rr_ptr_nx;
         cnt       <= cnt_nx;
         spi_start <= start_nx;
      end
   end
endmodule

// File: tb/tb_lcd_spi_arbiter.sv
// Bench for lcd_spi_arbiter: vector table, hand sequences, and random traffic
// checked against an abstract owner/pause model.
module tb_lcd_spi_arbiter;
   localparam int NR   = 3;
   localparam int TO_A = 4;

   logic          clock, Reset;
   logic [2:0]    req, req_dc, req_last;
   logic [23:0]   req_data;
   logic          spi_avail, spi_busy;
   logic [2:0]    grant, req_ack, grant_l, req_ack_l;
   logic [7:0]    spi_data, spi_data_l;
   logic          spi_command, spi_start, idle, err_abort;
   logic          spi_command_l, spi_start_l, idle_l, err_abort_l;
   logic [17:0]   o_a;

   int n_cmp, n_bad;

   lcd_spi_arbiter #(.NREQ(NR), .TIMEOUT(TO_A)) dut (
      .clock(clock), .Reset(Reset), .req(req), .req_data(req_data), .req_dc(req_dc),
      .req_last(req_last), .grant(grant), .req_ack(req_ack), .spi_data(spi_data),
      .spi_command(spi_command), .spi_start(spi_start), .spi_avail(spi_avail),
      .spi_busy(spi_busy), .idle(idle), .err_abort(err_abort));

   lcd_spi_arbiter #(.NREQ(NR), .TIMEOUT(255)) dut_l (
      .clock(clock), .Reset(Reset), .req(req), .req_data(req_data), .req_dc(req_dc),
      .req_last(req_last), .grant(grant_l), .req_ack(req_ack_l), .spi_data(spi_data_l),
      .spi_command(spi_command_l), .spi_start(spi_start_l), .spi_avail(spi_avail),
      .spi_busy(spi_busy), .idle(idle_l), .err_abort(err_abort_l));

   assign o_a = {grant, req_ack, spi_data, spi_command, spi_start, idle, err_abort};

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic        rst;
      logic [2:0]  r, dc, last;
      logic [23:0] d;
      logic        av, busy;
      logic [17:0] exp;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t V(input logic rst, input logic [2:0] r, input logic [23:0] d,
                              input logic [2:0] dc, input logic [2:0] last, input logic av,
                              input logic busy, input logic [2:0] eg, input logic [2:0] ea,
                              input logic [7:0] ed, input logic ec, input logic es,
                              input logic ei, input logic eab);
      vec_t v;
      v.rst = rst; v.r = r; v.d = d; v.dc = dc; v.last = last; v.av = av; v.busy = busy;
      v.exp = {eg, ea, ed, ec, es, ei, eab};
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drv(input logic [2:0] r, input logic [2:0] l, input logic av);
      @(negedge clock);
      req = r; req_last = l; spi_avail = av;
      #1;
   endtask

   task automatic do_reset();
      @(negedge clock);
      Reset = 1'b1; req = '0; req_last = '0; spi_avail = 1'b0; spi_busy = 1'b0;
      @(negedge clock);
      Reset = 1'b0;
   endtask

   // Reference model: who owns the bus, whether it is paused, and for how long.
   int m_owner, m_rr, m_cnt;
   bit m_hold;

   task automatic model_reset();
      m_owner = -1; m_rr = 0; m_cnt = 0; m_hold = 0;
   endtask

   function automatic int rr_find(input logic [2:0] r, input int from, input int skip);
      int k;
      for (int i = 0; i < NR; i++) begin
         k = (from + i) % NR;
         if (k != skip && r[k]) return k;
      end
      return -1;
   endfunction

   function automatic logic [17:0] model_out();
      logic [2:0] g, a;
      logic [7:0] sd;
      logic       cmd, moving;
      g      = (m_owner >= 0) ? 3'(1 << m_owner) : 3'b000;
      moving = (m_owner >= 0) && !m_hold;
      a      = (moving && spi_avail) ? g : 3'b000;
      sd     = (m_owner >= 0) ? req_data[8*m_owner +: 8] : 8'h00;
      cmd    = (m_owner >= 0) ? req_dc[m_owner] : 1'b0;
      return {g, a, sd, cmd, moving, (m_owner < 0) && !spi_busy, m_hold && (m_cnt == TO_A)};
   endfunction

   task automatic model_step();
      int o;
      o = m_owner;
      if (o < 0) begin
         m_owner = rr_find(req, m_rr, -1);
      end else if (!m_hold) begin
         if (spi_avail) begin
            if (req_last[o]) begin
               m_rr    = (o + 1) % NR;
               m_owner = rr_find(req, m_rr, o);
            end
         end else if (!req[o]) begin
            m_hold = 1; m_cnt = 0;
         end
      end else begin
         if (m_cnt == TO_A) begin
            m_rr = (o + 1) % NR; m_owner = -1; m_hold = 0;
         end else if (req[o]) m_hold = 0;
         else m_cnt++;
      end
   endtask

   int          rem[NR], drop[NR];
   logic [7:0]  cdat[NR];
   logic        cdc[NR];
   logic [17:0] ex;
   logic [2:0]  ackv;

   initial begin
      n_cmp = 0; n_bad = 0;
      Reset = 1'b1; req = '0; req_data = '0; req_dc = '0; req_last = '0;
      spi_avail = 1'b0; spi_busy = 1'b0;

      tbl.push_back(V(0,3'b010,24'h008000,3'b000,3'b000,0,0, 3'b000,3'b000,8'h00,0,0,1,0));
      tbl.push_back(V(0,3'b010,24'h008000,3'b000,3'b000,0,0, 3'b010,3'b000,8'h80,0,1,0,0));
      tbl.push_back(V(0,3'b010,24'h008000,3'b000,3'b000,1,1, 3'b010,3'b010,8'h80,0,1,0,0));
      tbl.push_back(V(0,3'b010,24'h003C00,3'b010,3'b010,0,1, 3'b010,3'b000,8'h3C,1,1,0,0));
      tbl.push_back(V(0,3'b010,24'h003C00,3'b010,3'b010,1,1, 3'b010,3'b010,8'h3C,1,1,0,0));
      tbl.push_back(V(0,3'b000,24'h000000,3'b000,3'b000,0,1, 3'b000,3'b000,8'h00,0,0,0,0));
      tbl.push_back(V(0,3'b000,24'h000000,3'b000,3'b000,0,0, 3'b000,3'b000,8'h00,0,0,1,0));
      tbl.push_back(V(1,3'b111,24'hC2B1A0,3'b101,3'b111,0,0, 3'b000,3'b000,8'h00,0,0,1,0));
      tbl.push_back(V(0,3'b111,24'hC2B1A0,3'b101,3'b111,0,0, 3'b000,3'b000,8'h00,0,0,1,0));
      tbl.push_back(V(0,3'b111,24'hC2B1A0,3'b101,3'b111,0,0, 3'b001,3'b000,8'hA0,1,1,0,0));
      tbl.push_back(V(0,3'b111,24'hC2B1A0,3'b101,3'b111,1,0, 3'b001,3'b001,8'hA0,1,1,0,0));
      tbl.push_back(V(0,3'b110,24'hC2B1A0,3'b101,3'b111,0,0, 3'b010,3'b000,8'hB1,0,1,0,0));
      tbl.push_back(V(0,3'b110,24'hC2B1A0,3'b101,3'b111,1,0, 3'b010,3'b010,8'hB1,0,1,0,0));
      tbl.push_back(V(0,3'b100,24'hC2B1A0,3'b101,3'b111,0,0, 3'b100,3'b000,8'hC2,1,1,0,0));
      tbl.push_back(V(0,3'b100,24'hC2B1A0,3'b101,3'b111,1,0, 3'b100,3'b100,8'hC2,1,1,0,0));
      tbl.push_back(V(0,3'b000,24'hC2B1A0,3'b101,3'b111,0,0, 3'b000,3'b000,8'h00,0,0,1,0));
      tbl.push_back(V(0,3'b000,24'hC2B1A0,3'b101,3'b111,1,0, 3'b000,3'b000,8'h00,0,0,1,0));

      @(negedge clock);
      @(negedge clock);
      Reset = 1'b0;

      foreach (tbl[i]) begin
         @(negedge clock);
         Reset = tbl[i].rst; req = tbl[i].r; req_data = tbl[i].d; req_dc = tbl[i].dc;
         req_last = tbl[i].last; spi_avail = tbl[i].av; spi_busy = tbl[i].busy;
         #1;
         chk($sformatf("vec%0d", i), o_a, tbl[i].exp);
      end

      req_data = 24'hC2B1A0; req_dc = 3'b101;

      // Packet lock: req2 waits for the end of req0's 4-byte packet.
      do_reset();
      drv(3'b001, 3'b000, 0); chk("lock_idle", grant, 3'b000);
      drv(3'b001, 3'b000, 1); chk("lock_b1_ack", req_ack, 3'b001);
      for (int b = 2; b <= 4; b++) begin
         drv(3'b101, 3'b000, 0);
         chk("lock_grant", grant, 3'b001); chk("lock_start", spi_start, 1'b1);
         drv(3'b101, (b == 4) ? 3'b001 : 3'b000, 1);
         chk("lock_ack", {grant, req_ack}, {3'b001, 3'b001});
      end
      drv(3'b100, 3'b000, 0);
      chk("lock_handover", {grant, spi_start}, {3'b100, 1'b1});

      // Permanent drop with a short timeout.
      do_reset();
      drv(3'b010, 3'b000, 0); chk("to_idle", grant, 3'b000);
      drv(3'b010, 3'b000, 0); chk("to_grant", {grant, spi_start}, {3'b010, 1'b1});
      drv(3'b101, 3'b000, 0); chk("to_drop", {grant, spi_start}, {3'b010, 1'b1});
      for (int i = 0; i < TO_A; i++) begin
         drv(3'b101, 3'b000, (i == 1));
         chk($sformatf("to_hold%0d", i), {grant, req_ack, spi_start, err_abort},
             {3'b010, 3'b000, 1'b0, 1'b0});
      end
      drv(3'b101, 3'b000, 0); chk("to_abort", {grant, err_abort}, {3'b010, 1'b1});
      drv(3'b101, 3'b000, 0); chk("to_release", {grant, err_abort}, {3'b000, 1'b0});
      drv(3'b101, 3'b000, 0); chk("to_next_rr", {grant, spi_start}, {3'b100, 1'b1});

      // Drop and recovery on the long-timeout instance.
      do_reset();
      drv(3'b001, 3'b000, 0);
      drv(3'b001, 3'b000, 1); chk("rec_ack1", {grant_l, req_ack_l}, {3'b001, 3'b001});
      for (int i = 0; i < 10; i++) begin
         drv(3'b000, 3'b000, (i == 5));
         chk($sformatf("rec_hold%0d", i), {grant_l, req_ack_l, spi_start_l, err_abort_l},
             {3'b001, 3'b000, (i == 0), 1'b0});
      end
      drv(3'b001, 3'b001, 0); chk("rec_back", {grant_l, spi_start_l}, {3'b001, 1'b0});
      drv(3'b001, 3'b001, 1);
      chk("rec_resume", {grant_l, req_ack_l, spi_start_l, spi_data_l}, {3'b001, 3'b001, 1'b1, 8'hA0});
      drv(3'b000, 3'b000, 0); chk("rec_done", {grant_l, spi_start_l}, {3'b000, 1'b0});

      // Asynchronous reset in the middle of a transfer.
      do_reset();
      drv(3'b001, 3'b000, 0);
      drv(3'b001, 3'b000, 0); chk("rst_pre", grant, 3'b001);
      @(negedge clock);
      spi_avail = 1'b1; #2 Reset = 1'b1; #1;
      chk("rst_async", o_a, 18'h00002);
      @(negedge clock);
      Reset = 1'b0;

      // Random traffic against the model.
      do_reset();
      model_reset();
      for (int k = 0; k < NR; k++) begin
         rem[k] = 0; drop[k] = 0; cdat[k] = 8'($urandom); cdc[k] = 1'($urandom);
      end
      for (int cyc = 0; cyc < 4000; cyc++) begin
         @(negedge clock);
         for (int k = 0; k < NR; k++) begin
            req[k]              = (rem[k] > 0) && (drop[k] == 0);
            req_last[k]         = (rem[k] == 1);
            req_data[8*k +: 8]  = cdat[k];
            req_dc[k]           = cdc[k];
         end
         spi_avail = 1'($urandom);
         spi_busy  = 1'($urandom);
         Reset     = ($urandom_range(499, 0) == 0);
         if (Reset) model_reset();
         #1;
         ex = model_out();
         chk($sformatf("rand%0d", cyc), o_a, ex);
         ackv = ex[14:12];
         if (!Reset) model_step();
         for (int k = 0; k < NR; k++) begin
            if (ackv[k] && rem[k] > 0) begin
               rem[k]--; cdat[k] = 8'($urandom); cdc[k] = 1'($urandom);
            end
            if (drop[k] > 0) drop[k]--;
            if (rem[k] == 0 && $urandom_range(3, 0) == 0) rem[k] = $urandom_range(4, 1);
            else if (rem[k] > 0 && drop[k] == 0 && $urandom_range(19, 0) == 0)
               drop[k] = $urandom_range(7, 1);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
